// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - next-PC select encoding and branch-mode constants shared by pc_sequencer
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_JMP,
    SEL_BR,
    SEL_SEQ
  } sel_t;

  localparam logic BRMODE_BNE = 1'b0;
  localparam logic BRMODE_BEQ = 1'b1;

  // Priority: stall > ret > call/j > taken branch > sequential.
  // A ret that finds the stack empty falls through to the sequential address.
  function automatic sel_t pick_sel(input logic stall, input logic ret_req,
                                    input logic stack_empty, input logic jmp,
                                    input logic taken);
    sel_t sel;
    sel = SEL_SEQ;
    if (stall)        sel = SEL_HOLD;
    else if (ret_req) sel = stack_empty ? SEL_SEQ : SEL_RET;
    else if (jmp)     sel = SEL_JMP;
    else if (taken)   sel = SEL_BR;
    return sel;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full drops the oldest entry
module pc_ras #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               top,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [AW-1:0] wr_idx;
  logic          wr_en;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign top   = mem[ptr];
  assign count = cnt;

  // push+pop together replaces the top entry in place; on an empty stack nothing is written
  assign wr_en  = push && !(pop && empty);
  assign wr_idx = pop ? ptr : ptr + AW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (push && pop) begin
      if (empty) err <= 1'b1;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      if (full) err <= 1'b1;
      else      cnt <= cnt + CW'(1);
    end else if (pop) begin
      if (empty) begin
        err <= 1'b1;
      end else begin
        ptr <= ptr - AW'(1);
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Entry contents are not reset; only pointer and count define validity.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter with jump/branch/call/ret; PC_SEQUENCER_RAS_EN builds the return stack in
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int PC_W      = 7,
  parameter int JADX_W    = 26,
  parameter int BR_W      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              j,
  input  logic [JADX_W-1:0] jAdx,
  input  logic              br,
  input  logic [BR_W-1:0]   brAdx,
  input  logic              z,
  input  logic              brMode,
  input  logic              call,
  input  logic              ret,
  output logic [PC_W-1:0]   prgCount,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  localparam int EW = (BR_W > PC_W) ? BR_W : PC_W;

  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] ras_top;
  logic [PC_W-1:0] next_pc;
  logic [EW-1:0]   br_ext;
  logic            taken;
  logic            ret_req;
  logic            jmp;
  logic            unused_bits;
  sel_t            sel;

  assign seq    = prgCount + PC_W'(1);
  assign br_ext = EW'($signed(brAdx));
  assign br_tgt = seq + br_ext[PC_W-1:0];
  assign j_tgt  = jAdx[PC_W-1:0];
  assign taken  = br & ((brMode == BRMODE_BEQ) ? z : ~z);

`ifdef PC_SEQUENCER_RAS_EN
  logic [$clog2(RAS_DEPTH):0] ras_count;

  assign ret_req = ret;
  assign jmp     = j | call;

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (call & ~stall),
    .pop   (ret & ~stall),
    .din   (seq),
    .top   (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty),
    .err   (ras_err)
  );

  assign unused_bits = ^{jAdx, br_ext, ras_count};
`else
  // Without the stack, call degenerates to a plain jump and ret is ignored.
  assign ret_req     = 1'b0;
  assign jmp         = j | call;
  assign ras_top     = '0;
  assign ras_empty   = 1'b1;
  assign ras_full    = 1'b0;
  assign ras_err     = 1'b0;
  assign unused_bits = ^{jAdx, br_ext, ret, ras_top};
`endif

  always_comb begin
    next_pc = seq;
    sel     = pick_sel(stall, ret_req, ras_empty, jmp, taken);
    case (sel)
      SEL_HOLD: next_pc = prgCount;
      SEL_RET:  next_pc = ras_top;
      SEL_JMP:  next_pc = j_tgt;
      SEL_BR:   next_pc = br_tgt;
      SEL_SEQ:  next_pc = seq;
      default:  next_pc = seq;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prgCount <= '0;
    else       prgCount <= next_pc;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer (stack tests need PC_SEQUENCER_RAS_EN)
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        j;
  logic [25:0] jAdx;
  logic        br;
  logic [31:0] brAdx;
  logic        z;
  logic        brMode;
  logic        call;
  logic        ret;
  logic [6:0]  prgCount;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_err;

  int n_checks;
  int n_errors;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .j         (j),
    .jAdx      (jAdx),
    .br        (br),
    .brAdx     (brAdx),
    .z         (z),
    .brMode    (brMode),
    .call      (call),
    .ret       (ret),
    .prgCount  (prgCount),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; j = 0; jAdx = '0; br = 0; brAdx = '0; z = 0; brMode = 0; call = 0; ret = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic goto_pc(input logic [25:0] target);
    j = 1; jAdx = target;
    step();
    j = 0; jAdx = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #2;
    n_checks++; if (prgCount !== 7'd0) begin n_errors++; $display("FAIL reset_pc: prgCount=%0d expected 0", prgCount); end
    n_checks++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin n_errors++; $display("FAIL reset_flags: empty/full/err=%b expected 100", {ras_empty, ras_full, ras_err}); end
    step();
    reset = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      n_checks++; if (prgCount !== 7'(i)) begin n_errors++; $display("FAIL idle_count: prgCount=%0d expected %0d", prgCount, i); end
    end
    #2;
    reset = 1;
    #1;
    n_checks++; if (prgCount !== 7'd0) begin n_errors++; $display("FAIL async_reset: prgCount=%0d expected 0", prgCount); end
    reset = 0;
    step();
    n_checks++; if (prgCount !== 7'd1) begin n_errors++; $display("FAIL first_after_reset: prgCount=%0d expected 1", prgCount); end
  endtask

  task automatic test_jump_branch();
    do_reset();
    for (int i = 0; i < 5; i++) step();
    n_checks++; if (prgCount !== 7'd5) begin n_errors++; $display("FAIL reach_5: prgCount=%0d expected 5", prgCount); end
    goto_pc(26'd15);
    n_checks++; if (prgCount !== 7'd15) begin n_errors++; $display("FAIL jump_15: prgCount=%0d expected 15", prgCount); end
    br = 1; brMode = 0; z = 0; brAdx = 32'hFFFF_FFFD;
    step();
    n_checks++; if (prgCount !== 7'd13) begin n_errors++; $display("FAIL bne_taken: prgCount=%0d expected 13", prgCount); end
    br = 0;
    goto_pc(26'd15);
    br = 1; brMode = 0; z = 1; brAdx = 32'hFFFF_FFFD;
    step();
    n_checks++; if (prgCount !== 7'd16) begin n_errors++; $display("FAIL bne_not_taken: prgCount=%0d expected 16", prgCount); end
    brMode = 1; z = 1; brAdx = 32'd10;
    step();
    n_checks++; if (prgCount !== 7'd27) begin n_errors++; $display("FAIL beq_taken: prgCount=%0d expected 27", prgCount); end
    brMode = 1; z = 0;
    step();
    n_checks++; if (prgCount !== 7'd28) begin n_errors++; $display("FAIL beq_not_taken: prgCount=%0d expected 28", prgCount); end
    brMode = 0; z = 0; brAdx = 32'd5;
    j = 1; jAdx = 26'h3F0_0064;
    step();
    n_checks++; if (prgCount !== 7'd100) begin n_errors++; $display("FAIL jump_over_branch: prgCount=%0d expected 100", prgCount); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    goto_pc(26'd127);
    step();
    n_checks++; if (prgCount !== 7'd0) begin n_errors++; $display("FAIL seq_wrap: prgCount=%0d expected 0", prgCount); end
    goto_pc(26'd126);
    br = 1; brMode = 0; z = 0; brAdx = 32'd2;
    step();
    n_checks++; if (prgCount !== 7'd1) begin n_errors++; $display("FAIL branch_wrap: prgCount=%0d expected 1", prgCount); end
    brAdx = 32'hFFFF_FFF0;
    step();
    n_checks++; if (prgCount !== 7'd114) begin n_errors++; $display("FAIL branch_back_wrap: prgCount=%0d expected 114", prgCount); end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    goto_pc(26'd20);
    stall = 1; j = 1; jAdx = 26'd99; br = 1; brAdx = 32'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (prgCount !== 7'd20) begin n_errors++; $display("FAIL stall_hold: prgCount=%0d expected 20", prgCount); end
    end
    clear_inputs();
    step();
    n_checks++; if (prgCount !== 7'd21) begin n_errors++; $display("FAIL stall_release: prgCount=%0d expected 21", prgCount); end
  endtask

`ifdef PC_SEQUENCER_RAS_EN
  task automatic test_call_ret();
    do_reset();
    goto_pc(26'd3);
    call = 1; jAdx = 26'd40;
    step();
    n_checks++; if (prgCount !== 7'd40) begin n_errors++; $display("FAIL call_40: prgCount=%0d expected 40", prgCount); end
    n_checks++; if (ras_empty !== 1'b0) begin n_errors++; $display("FAIL call_not_empty: ras_empty=%b expected 0", ras_empty); end
    jAdx = 26'd60;
    step();
    n_checks++; if (prgCount !== 7'd60) begin n_errors++; $display("FAIL call_60: prgCount=%0d expected 60", prgCount); end
    call = 0; ret = 1;
    step();
    n_checks++; if (prgCount !== 7'd41) begin n_errors++; $display("FAIL ret_41: prgCount=%0d expected 41", prgCount); end
    step();
    n_checks++; if (prgCount !== 7'd4) begin n_errors++; $display("FAIL ret_4: prgCount=%0d expected 4", prgCount); end
    n_checks++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin n_errors++; $display("FAIL ret_flags: empty/full/err=%b expected 100", {ras_empty, ras_full, ras_err}); end
    clear_inputs();
  endtask

  task automatic test_overflow();
    logic [6:0] exp_ret [4];
    exp_ret[0] = 7'd41; exp_ret[1] = 7'd31; exp_ret[2] = 7'd21; exp_ret[3] = 7'd11;
    do_reset();
    call = 1;
    for (int i = 1; i <= 4; i++) begin
      jAdx = 26'(i * 10);
      step();
    end
    n_checks++; if ({ras_full, ras_err} !== 2'b10) begin n_errors++; $display("FAIL full_no_err: full/err=%b expected 10", {ras_full, ras_err}); end
    jAdx = 26'd50;
    step();
    n_checks++; if (prgCount !== 7'd50) begin n_errors++; $display("FAIL call_5th: prgCount=%0d expected 50", prgCount); end
    n_checks++; if ({ras_full, ras_err} !== 2'b11) begin n_errors++; $display("FAIL overflow_flags: full/err=%b expected 11", {ras_full, ras_err}); end
    call = 0; ret = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (prgCount !== exp_ret[i]) begin n_errors++; $display("FAIL ret_newest: prgCount=%0d expected %0d", prgCount, exp_ret[i]); end
    end
    n_checks++; if (ras_empty !== 1'b1) begin n_errors++; $display("FAIL drained_empty: ras_empty=%b expected 1", ras_empty); end
    step();
    n_checks++; if (prgCount !== 7'd12) begin n_errors++; $display("FAIL underflow_seq: prgCount=%0d expected 12", prgCount); end
    n_checks++; if ({ras_empty, ras_err} !== 2'b11) begin n_errors++; $display("FAIL underflow_flags: empty/err=%b expected 11", {ras_empty, ras_err}); end
    clear_inputs();
  endtask

  task automatic test_call_ret_together();
    do_reset();
    call = 1; jAdx = 26'd20;
    step();
    ret = 1; jAdx = 26'd70;
    step();
    n_checks++; if (prgCount !== 7'd1) begin n_errors++; $display("FAIL swap_pc: prgCount=%0d expected 1", prgCount); end
    n_checks++; if ({ras_empty, ras_full, ras_err} !== 3'b000) begin n_errors++; $display("FAIL swap_flags: empty/full/err=%b expected 000", {ras_empty, ras_full, ras_err}); end
    call = 0; stall = 1;
    step();
    step();
    n_checks++; if ({prgCount, ras_empty} !== {7'd1, 1'b0}) begin n_errors++; $display("FAIL stall_ret: pc/empty=%0d/%b expected 1/0", prgCount, ras_empty); end
    stall = 0;
    step();
    n_checks++; if (prgCount !== 7'd21) begin n_errors++; $display("FAIL swap_ret: prgCount=%0d expected 21", prgCount); end
    call = 1; jAdx = 26'd90;
    step();
    n_checks++; if (prgCount !== 7'd22) begin n_errors++; $display("FAIL empty_swap_pc: prgCount=%0d expected 22", prgCount); end
    n_checks++; if ({ras_empty, ras_err} !== 2'b11) begin n_errors++; $display("FAIL empty_swap_flags: empty/err=%b expected 11", {ras_empty, ras_err}); end
    clear_inputs();
  endtask
`else
  task automatic test_no_ras();
    do_reset();
    goto_pc(26'd3);
    call = 1; jAdx = 26'd40;
    step();
    n_checks++; if (prgCount !== 7'd40) begin n_errors++; $display("FAIL call_as_jump: prgCount=%0d expected 40", prgCount); end
    call = 0; ret = 1;
    step();
    n_checks++; if (prgCount !== 7'd41) begin n_errors++; $display("FAIL ret_ignored: prgCount=%0d expected 41", prgCount); end
    j = 1; jAdx = 26'd77;
    step();
    n_checks++; if (prgCount !== 7'd77) begin n_errors++; $display("FAIL ret_with_jump: prgCount=%0d expected 77", prgCount); end
    n_checks++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin n_errors++; $display("FAIL const_flags: empty/full/err=%b expected 100", {ras_empty, ras_full, ras_err}); end
    clear_inputs();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_jump_branch();
    test_wrap();
    test_stall();
`ifdef PC_SEQUENCER_RAS_EN
    test_call_ret();
    test_overflow();
    test_call_ret_together();
`else
    test_no_ras();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 7, program-counter width.
REQ-002 SHALL have parameter JADX_W, default 26, jump-address field width (JADX_W >= PC_W).
REQ-003 SHALL have parameter BR_W, default 32, signed branch-offset width.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, >= 2).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 stall  input  1  hold PC and stack this cycle.
REQ-009 j  input  1  absolute jump.
REQ-010 jAdx  input  JADX_W  jump target field.
REQ-011 br  input  1  conditional branch.
REQ-012 brAdx  input  BR_W  signed branch offset, in instructions.
REQ-013 z  input  1  ALU zero flag.
REQ-014 brMode  input  1  0: taken when ~z (bne); 1: taken when z (beq).
REQ-015 call  input  1  jump to jAdx and push return address.
REQ-016 ret  input  1  jump to popped return address.
REQ-017 prgCount  output  PC_W  current program counter.
REQ-018 ras_empty  output  1  stack holds 0 entries.
REQ-019 ras_full  output  1  stack holds RAS_DEPTH entries.
REQ-020 ras_err  output  1  sticky overflow/underflow flag.

Function
REQ-021 SHALL compute seq = prgCount+1 modulo 2^PC_W.
REQ-022 SHALL compute brTgt = seq + brAdx (sign-extended), truncated to PC_W bits; wrap silent.
REQ-023 SHALL compute jTgt = jAdx[PC_W-1:0].
REQ-024 SHALL define taken = br & (brMode ? z : ~z).
REQ-025 SHALL select next PC with priority: stall (hold) > ret > call/j > taken > seq.
REQ-026 SHALL update prgCount on each rising clk edge; new target visible 1 cycle after request.
REQ-027 call SHALL push seq; ret SHALL pop and use the top entry as next PC.
REQ-028 Push when full: oldest entry dropped (circular), count stays RAS_DEPTH, ras_err set.
REQ-029 ret when empty: next PC = seq, count stays 0, ras_err set.
REQ-030 call and ret together: next PC = top entry, top overwritten with seq, count unchanged (empty: REQ-029 applies, no push).
REQ-031 stall=1: prgCount, stack contents, count and ras_err unchanged; all other inputs ignored.
REQ-032 ras_empty/ras_full SHALL be registered-count decodes, valid in the same cycle as prgCount.

Reset
REQ-033 reset=1 SHALL immediately force prgCount=0, stack count=0, ras_err=0, ras_empty=1, ras_full=0.
REQ-034 Reset mid-call/ret SHALL discard the pending operation; stack entry contents need not clear.
REQ-035 First post-reset edge SHALL advance to 1 absent control inputs.

Configuration
REQ-036 Macro PC_SEQUENCER_RAS_EN SHALL compile the return-address stack in.
REQ-037 Without it: ret ignored, call behaves as j, ras_empty=1, ras_full=0, ras_err=0 constant, no stack storage.

Structure
REQ-038 Shared package pc_pkg SHALL hold next-PC select enum (SEL_HOLD, SEL_RET, SEL_JMP, SEL_BR, SEL_SEQ) and BRMODE_BNE/BRMODE_BEQ constants.
REQ-039 Stack SHALL be sub-module pc_ras (push, pop, top, count, full, empty, err).
REQ-040 Adders SHALL be inferred arithmetic, no instantiated ripple adders.

Verification
REQ-041 Reset, 10 idle cycles -> prgCount 0,1,...,10; reset mid-count -> 0 without clock edge.
REQ-042 At PC=5, j=1 jAdx=15 -> 15; br=1 brMode=0 z=0 brAdx=-3 at 15 -> 13; same with z=1 -> 16.
REQ-043 At PC=127 idle -> 0; br=1 taken brAdx=2 at 126 -> 1 (wrap).
REQ-044 call at 3 (jAdx=40), call at 40 (jAdx=60), ret, ret -> 40,60,41,4; ras_empty after last ret.
REQ-045 5 nested calls (RAS_DEPTH=4) -> ras_full, ras_err=1, 4 rets return newest 4; 5th ret -> seq, ras_err stays 1.
REQ-046 stall=1 with j=1 for 3 cycles -> prgCount constant; build without PC_SEQUENCER_RAS_EN: call=jump, ret ignored.
